// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: one-at-a-time fetch, handshake to decode, sticky fault
//
// Purpose:
//   Issues one instruction fetch at a time to memory and holds the returned
//   word for decode. The next fetch address comes only from execute (dnpc).
//   This block never increments the PC itself. An access fault on a
//   response, or a misaligned dnpc, parks the unit in FAULT until rst.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_req_valid/ready/addr      fetch request channel to memory
//   mem_rsp_valid/data/err        fetch response channel from memory
//   inst, pc, inst_valid          registered instruction and its PC for decode
//   inst_ready                    decode consumes inst this cycle
//   dnpc, dnpc_valid              next PC from execute
//   fetch_fault                   sticky fault flag
module ifu #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'(32'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ISA_WIDTH-1:0] mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [ISA_WIDTH-1:0] mem_rsp_data,
  input  logic                 mem_rsp_err,
  output logic [ISA_WIDTH-1:0] inst,
  output logic [ISA_WIDTH-1:0] pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  input  logic [ISA_WIDTH-1:0] dnpc,
  input  logic                 dnpc_valid,
  output logic                 fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_NPC   = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [ISA_WIDTH-1:0] pc_q, pc_d;
  logic [ISA_WIDTH-1:0] inst_q, inst_d;
  logic                 req_valid_q, req_valid_d;
  logic                 inst_valid_q, inst_valid_d;
  logic                 fault_q, fault_d;

  // Misaligned targets are trapped here rather than fetched.
  logic dnpc_misaligned;
  assign dnpc_misaligned = (dnpc[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      // pc_q is not touched while in REQ, so the address stays stable
      // across back-pressure.
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            state_d = S_FAULT;
          end else begin
            inst_d  = mem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end

      // dnpc is only honoured together with the consuming handshake; a
      // dnpc presented while decode stalls is ignored.
      S_HOLD: begin
        if (inst_ready) begin
          if (dnpc_valid) begin
            pc_d    = dnpc;
            state_d = dnpc_misaligned ? S_FAULT : S_REQ;
          end else begin
            state_d = S_NPC;
          end
        end
      end

      S_NPC: begin
        if (dnpc_valid) begin
          pc_d    = dnpc;
          state_d = dnpc_misaligned ? S_FAULT : S_REQ;
        end
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: they are decoded from the next state so that
    // they line up with the state they belong to.
    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
    fault_d      = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign inst_valid    = inst_valid_q;
  assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu with directed scenarios and a random transaction model
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] dnpc;
  logic        dnpc_valid;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  ifu dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst          (inst),
    .pc            (pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .dnpc          (dnpc),
    .dnpc_valid    (dnpc_valid),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    inst_ready    = 1'b0;
    dnpc          = '0;
    dnpc_valid    = 1'b0;
  endtask

  // Leaves the DUT in the single post-reset idle cycle.
  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // From the request state: accept immediately, answer next cycle; ends in HOLD.
  task automatic fetch_to_hold(input logic [31:0] word);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = word;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", mem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%0b exp=0", inst_valid); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", fetch_fault); end
    checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
    checks++; if (pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
  endtask

  task automatic test_basic_fetch();
    apply_reset();
    step(); // cycle 2: request
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin failures++; $display("FAIL basic_req got=%0b/%h exp=1/%h", mem_req_valid, mem_req_addr, RST_PC); end
    mem_req_ready = 1'b1;
    step(); // cycle 3: waiting
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%0b exp=0", mem_req_valid); end
    step(); // cycle 4: response
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", inst_valid); end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0513;
    step(); // cycle 5
    mem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 || pc !== RST_PC) begin failures++; $display("FAIL basic_inst got=%0b/%h/%h exp=1/00000513/%h", inst_valid, inst, pc, RST_PC); end
  endtask

  task automatic test_req_stall();
    apply_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin failures++; $display("FAIL stall_req cyc=%0d got=%0b/%h exp=1/%h", i, mem_req_valid, mem_req_addr, RST_PC); end
      step();
    end
    mem_req_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_single_req cyc=%0d got=%0b exp=0", i, mem_req_valid); end
      step();
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    logic [31:0] word;
    word = $urandom;
    apply_reset();
    step();
    fetch_to_hold(word);
    for (int i = 0; i < 4; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst !== word || pc !== RST_PC) begin failures++; $display("FAIL hold_stable cyc=%0d got=%0b/%h/%h exp=1/%h/%h", i, inst_valid, inst, pc, word, RST_PC); end
      dnpc_valid = 1'b1; // must be ignored without inst_ready
      dnpc       = 32'h1234_5670;
      step();
    end
    inst_ready = 1'b1;
    dnpc       = 32'h8000_0010;
    step();
    clear_inputs();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010 || inst_valid !== 1'b0) begin failures++; $display("FAIL hold_redirect got=%0b/%h/%0b exp=1/80000010/0", mem_req_valid, mem_req_addr, inst_valid); end
  endtask

  task automatic test_rsp_fault();
    apply_reset();
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_err   = 1'b1;
    mem_rsp_data  = 32'hdead_beef;
    step();
    checks++; if (fetch_fault !== 1'b1 || inst !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rsp_fault got=%0b/%h/%0b exp=1/0/0", fetch_fault, inst, inst_valid); end
    mem_rsp_err   = 1'b0;
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    dnpc_valid    = 1'b1;
    dnpc          = 32'h8000_0100;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL fault_sticky cyc=%0d got=%0b/%0b/%0b exp=1/0/0", i, fetch_fault, mem_req_valid, inst_valid); end
    end
    clear_inputs();
  endtask

  task automatic test_misaligned_npc();
    apply_reset();
    step();
    fetch_to_hold(32'h0000_0013);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0 || fetch_fault !== 1'b0) begin failures++; $display("FAIL npc_wait got=%0b/%0b/%0b exp=0/0/0", inst_valid, mem_req_valid, fetch_fault); end
    dnpc_valid = 1'b1;
    dnpc       = 32'h8000_0002;
    step();
    clear_inputs();
    checks++; if (fetch_fault !== 1'b1 || pc !== 32'h8000_0002 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL misaligned got=%0b/%h/%0b exp=1/80000002/0", fetch_fault, pc, mem_req_valid); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    step();
    fetch_to_hold(32'hcafe_f00d);
    inst_ready = 1'b1;
    dnpc_valid = 1'b1;
    dnpc       = 32'h8000_0040;
    step();
    clear_inputs();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst           = 1'b0;
    mem_rsp_valid = 1'b1; // stray response arriving in IDLE
    mem_rsp_data  = 32'h0bad_0bad;
    checks++; if (inst !== 32'h0 || inst_valid !== 1'b0 || pc !== RST_PC) begin failures++; $display("FAIL midwait_reset got=%h/%0b/%h exp=0/0/%h", inst, inst_valid, pc, RST_PC); end
    step();
    mem_rsp_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC || inst !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL midwait_discard got=%0b/%h/%h/%0b exp=1/%h/0/0", mem_req_valid, mem_req_addr, inst, inst_valid, RST_PC); end
  endtask

  // Transaction-level model: each fetch must request the model PC and deliver
  // the word memory returned, tagged with that PC; the next PC is whatever
  // execute supplies, on either the direct or the delayed path.
  task automatic test_random();
    logic [31:0] pc_model;
    logic [31:0] word;
    logic [31:0] next_pc;
    int          n;
    apply_reset();
    step();
    pc_model = RST_PC;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== pc_model) begin failures++; $display("FAIL rnd_req t=%0d got=%0b/%h exp=1/%h", t, mem_req_valid, mem_req_addr, pc_model); end
        step();
      end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== pc_model) begin failures++; $display("FAIL rnd_req_acc t=%0d got=%0b/%h exp=1/%h", t, mem_req_valid, mem_req_addr, pc_model); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rnd_wait t=%0d got=%0b/%0b exp=0/0", t, mem_req_valid, inst_valid); end
        step();
      end
      word          = $urandom;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word;
      step();
      mem_rsp_valid = 1'b0;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        checks++; if (inst_valid !== 1'b1 || inst !== word || pc !== pc_model) begin failures++; $display("FAIL rnd_hold t=%0d got=%0b/%h/%h exp=1/%h/%h", t, inst_valid, inst, pc, word, pc_model); end
        dnpc_valid = $urandom_range(0, 1);
        dnpc       = $urandom;
        step();
      end
      checks++; if (inst_valid !== 1'b1 || inst !== word || pc !== pc_model) begin failures++; $display("FAIL rnd_inst t=%0d got=%0b/%h/%h exp=1/%h/%h", t, inst_valid, inst, pc, word, pc_model); end
      next_pc    = $urandom & 32'hffff_fffc;
      inst_ready = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        dnpc_valid = 1'b1;
        dnpc       = next_pc;
        step();
      end else begin
        dnpc_valid = 1'b0;
        step();
        inst_ready = 1'b0;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rnd_npc t=%0d got=%0b/%0b exp=0/0", t, inst_valid, mem_req_valid); end
          step();
        end
        dnpc_valid = 1'b1;
        dnpc       = next_pc;
        step();
      end
      clear_inputs();
      pc_model = next_pc;
    end
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== pc_model || fetch_fault !== 1'b0) begin failures++; $display("FAIL rnd_end got=%0b/%h/%0b exp=1/%h/0", mem_req_valid, mem_req_addr, fetch_fault, pc_model); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_fetch();
    test_req_stall();
    test_hold_stall();
    test_rsp_fault();
    test_misaligned_npc();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
